logic_unit_seq: RTL and testbench
=================================

# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the ALU; successor to the fixed 16-bit single-operation AND stage. It performs one of eight bitwise operations on WIDTH-bit operands, SLICE bits per clock, under a start/done handshake. It reports Z/N/C/V flags with the same semantics as the existing logic stages. It sits beside the other ALU functional units and feeds the ALU result/flag mux.

## Interface
- WIDTH, 16, operand/result width; must be ≥ 2.
- SLICE, 4, bits processed per cycle; WIDTH % SLICE must equal 0, otherwise elaboration fails.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while ready=1.
- op  input  3  operation select, latched with start.
- a  input  WIDTH  operand A, latched with start.
- b  input  WIDTH  operand B, latched with start.
- ready  output  1  high in IDLE only.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  registered result, held until the next accepted start.
- Z  output  1  result == 0.
- N  output  1  result[WIDTH-1].
- C  output  1  always 0.
- V  output  1  always 0.

## Operation
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 ANDN (a & ~b)
  - 111 NOTA (~a; b ignored)
- NSL = WIDTH/SLICE. The slice index counter has width max(1, clog2(NSL)).
- FSM states and transitions:
  - IDLE: ready=1. On start=1, latch a, b and op into internal registers, set idx=0, clear result to 0, and go to BUSY. On start=0, stay in IDLE.
  - BUSY: each cycle, compute slice idx (bits idx*SLICE +: SLICE) from the latched operands and write those bits into result, then increment idx. After writing slice NSL-1, register the flags from the complete next-result value and go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- start is ignored in BUSY and DONE. There is no queueing.
- Input changes after the accept edge have no effect, because operands are latched.
- Z, N, C and V are updated only on entry to DONE and hold until the next DONE.
- Bits of result not yet written during BUSY read as 0.
- Reset (asynchronous, including mid-operation) sets:
  - state = IDLE, idx = 0
  - result = 0
  - Z = N = C = V = 0
  - done = 0, ready = 1
  - any operation in flight is abandoned with no done pulse.
- When SLICE == WIDTH, NSL = 1 and there is a single BUSY cycle.

## Timing
- Edge E0: start is accepted and ready falls after E0.
- Edges E1..E_NSL: one slice is written per edge.
- After edge E_NSL: done=1 and flags are valid, for one cycle.
- After edge E_NSL+1: ready=1. A start asserted in that cycle is accepted.
- Accept-to-done latency is NSL cycles. Throughput is one operation per NSL+2 cycles.
- Defaults (WIDTH=16, SLICE=4): done in cycle 4 after accept; next accept at the earliest at E6.
- All outputs are registered except ready, which is decoded directly from the state register. There are no combinational paths from inputs to outputs.

## Structure
- Package logic_unit_pkg holds:
  - the op codes (OP_AND … OP_NOTA) as 3-bit localparams;
  - the state enum {IDLE, BUSY, DONE}.
- Sub-module logic_slice: combinational, parameter SLICE. Ports: op, a_s, b_s, y_s. It is instantiated once and driven from the latched operands through the idx mux.
- The top level holds the FSM, the index counter, the operand/op latches, the result register and the flag register.

## Test plan
- Reset, then AND with WIDTH=16, SLICE=4, a=0xF0F0, b=0xFF00 -> done pulses exactly 4 cycles after accept; result=0xF000, Z=0, N=1, C=0, V=0.
- XOR with a=b=0x1234 -> result=0x0000, Z=1, N=0. Then NOTA with a=0x0000 -> result=0xFFFF, Z=0, N=1.
- Sweep all 8 ops on random operands for configurations (16,4), (16,16), (32,8) and (8,1), compared against a golden model -> results match, and latency equals WIDTH/SLICE for each.
- Assert start during BUSY and DONE with different a, b and op -> ignored; the first result is unchanged. A start held high in the cycle ready returns is accepted at the next edge.
- Assert rst asynchronously (mid-cycle) during BUSY on the third slice -> all outputs cleared immediately, ready=1, no done pulse. A following operation completes correctly.
- After a completed NAND with a=0xFFFF, b=0xFFFF, change a and b freely while idle -> result=0x0000, Z=1, and both hold until the next done.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the sequential bitwise logic unit: op codes and FSM states.
package logic_unit_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_ANDN = 3'b110;
  localparam logic [2:0] OP_NOTA = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/logic_slice.sv
// Combinational bitwise operator applied to one SLICE-bit chunk of the operands.
module logic_slice
  import logic_unit_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [2:0]       op,
  input  logic [SLICE-1:0] a_s,
  input  logic [SLICE-1:0] b_s,
  output logic [SLICE-1:0] y_s
);

  always_comb begin
    y_s = '0;
    case (op)
      OP_AND:  y_s = a_s & b_s;
      OP_OR:   y_s = a_s | b_s;
      OP_XOR:  y_s = a_s ^ b_s;
      OP_NAND: y_s = ~(a_s & b_s);
      OP_NOR:  y_s = ~(a_s | b_s);
      OP_XNOR: y_s = ~(a_s ^ b_s);
      OP_ANDN: y_s = a_s & ~b_s;
      OP_NOTA: y_s = ~a_s;
      default: y_s = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: processes SLICE bits per clock under a start/done
// handshake and reports Z/N/C/V flags for the ALU result mux.
module logic_unit_seq
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             V
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_bad_cfg
    $error("logic_unit_seq: WIDTH must be >= 2 and a multiple of SLICE");
  end

  state_t            state;
  logic [IDXW-1:0]   idx;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [SLICE-1:0]  a_s;
  logic [SLICE-1:0]  b_s;
  logic [SLICE-1:0]  y_s;
  logic [WIDTH-1:0]  res_nxt;
  logic              last;
  logic              accept;

  assign ready  = (state == IDLE);
  assign accept = ready & start;
  assign last   = (idx == IDXW'(NSL - 1));

  assign a_s = a_q[SLICE*int'(idx) +: SLICE];
  assign b_s = b_q[SLICE*int'(idx) +: SLICE];

  logic_slice #(.SLICE(SLICE)) u_slice (
    .op  (op_q),
    .a_s (a_s),
    .b_s (b_s),
    .y_s (y_s)
  );

  // Result as it will look after the current slice is written; flags come from this.
  always_comb begin
    res_nxt = result;
    res_nxt[SLICE*int'(idx) +: SLICE] = y_s;
  end

  // Operand latches: pure data, captured on accept only.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_q <= op;
      a_q  <= a;
      b_q  <= b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      result <= '0;
      done   <= 1'b0;
      Z      <= 1'b0;
      N      <= 1'b0;
      C      <= 1'b0;
      V      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= BUSY;
            idx    <= '0;
            result <= '0;
          end
        end
        BUSY: begin
          result <= res_nxt;
          idx    <= idx + IDXW'(1);
          if (last) begin
            Z     <= (res_nxt == '0);
            N     <= res_nxt[WIDTH-1];
            C     <= 1'b0;
            V     <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Scoreboard bench for logic_unit_seq across four WIDTH/SLICE configurations.
module tb_logic_unit_seq;
  import logic_unit_pkg::*;

  typedef struct {
    logic [31:0] res;
    int          acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a32 = '0;
  logic [31:0] b32 = '0;

  logic [3:0]  rdy, dn, zf, nf, cf, vf;
  logic [15:0] r0, r1;
  logic [31:0] r2;
  logic [7:0]  r3;

  exp_t q[4][$];
  int   busy_until[4];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bit          inflight0 = 1'b0;
  logic [15:0] exp0 = '0;
  int          acc0 = 0;
  logic [15:0] last_r0 = '0;
  logic        last_z0 = 1'b0;
  logic        last_n0 = 1'b0;

  logic_unit_seq #(.WIDTH(16), .SLICE(4)) u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32[15:0]), .b(b32[15:0]),
    .ready(rdy[0]), .done(dn[0]), .result(r0), .Z(zf[0]), .N(nf[0]), .C(cf[0]), .V(vf[0]));
  logic_unit_seq #(.WIDTH(16), .SLICE(16)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32[15:0]), .b(b32[15:0]),
    .ready(rdy[1]), .done(dn[1]), .result(r1), .Z(zf[1]), .N(nf[1]), .C(cf[1]), .V(vf[1]));
  logic_unit_seq #(.WIDTH(32), .SLICE(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32), .b(b32),
    .ready(rdy[2]), .done(dn[2]), .result(r2), .Z(zf[2]), .N(nf[2]), .C(cf[2]), .V(vf[2]));
  logic_unit_seq #(.WIDTH(8), .SLICE(1)) u3 (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a32[7:0]), .b(b32[7:0]),
    .ready(rdy[3]), .done(dn[3]), .result(r3), .Z(zf[3]), .N(nf[3]), .C(cf[3]), .V(vf[3]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int wof(int k);
    case (k)
      0: return 16;
      1: return 16;
      2: return 32;
      default: return 8;
    endcase
  endfunction

  function automatic int nsl(int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 4;
      default: return 8;
    endcase
  endfunction

  // Reference: the plain boolean meaning of each op, masked to the configured width.
  function automatic logic [31:0] model(logic [2:0] o, logic [31:0] x, logic [31:0] y, int w);
    logic [31:0] r;
    logic [31:0] mask;
    case (o)
      3'd0: r = x & y;
      3'd1: r = x | y;
      3'd2: r = x ^ y;
      3'd3: r = ~(x & y);
      3'd4: r = ~(x | y);
      3'd5: r = ~(x ^ y);
      3'd6: r = x & ~y;
      default: r = ~x;
    endcase
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    return r & mask;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    checks++;
    if (act !== ex) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, ex, cyc);
    end
  endtask

  task automatic mon(int k, logic [31:0] r, logic z, logic n, logic c, logic v);
    exp_t e;
    int   w;
    if (dn[k]) begin
      if (q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done%0d: got done=1 expected no pending op at cycle %0d", k, cyc);
      end else begin
        e = q[k].pop_front();
        w = wof(k);
        chk($sformatf("result%0d", k), r, e.res);
        chk($sformatf("Z%0d", k), 32'(z), 32'(e.res == 32'h0));
        chk($sformatf("N%0d", k), 32'(n), 32'(e.res[w-1]));
        chk($sformatf("C%0d", k), 32'(c), 32'h0);
        chk($sformatf("V%0d", k), 32'(v), 32'h0);
        chk($sformatf("latency%0d", k), 32'(cyc - e.acc), 32'(nsl(k)));
      end
    end
  endtask

  // Monitor: done-driven scoreboard for all units plus slice-by-slice view of unit 0.
  always @(negedge clk) begin
    if (!rst) begin
      int          k;
      logic [15:0] m;
      mon(0, 32'(r0), zf[0], nf[0], cf[0], vf[0]);
      mon(1, 32'(r1), zf[1], nf[1], cf[1], vf[1]);
      mon(2, r2,      zf[2], nf[2], cf[2], vf[2]);
      mon(3, 32'(r3), zf[3], nf[3], cf[3], vf[3]);
      k = cyc - acc0;
      if (inflight0 && k >= 0) begin
        m = (k >= 4) ? 16'hFFFF : 16'((32'h1 << (k * 4)) - 32'h1);
        chk("partial_result", 32'(r0), 32'(exp0 & m));
        if (k >= 4) begin
          last_r0   = exp0;
          last_z0   = (exp0 == 16'h0);
          last_n0   = exp0[15];
          inflight0 = 1'b0;
        end else begin
          chk("busy_Z_hold", 32'(zf[0]), 32'(last_z0));
          chk("busy_N_hold", 32'(nf[0]), 32'(last_n0));
        end
      end else begin
        chk("idle_result_hold", 32'(r0), 32'(last_r0));
        chk("idle_Z_hold", 32'(zf[0]), 32'(last_z0));
        chk("idle_N_hold", 32'(nf[0]), 32'(last_n0));
      end
    end
  end

  // Called at a falling edge: present inputs, book any expected accepts, advance one cycle.
  task automatic drive(bit st, logic [2:0] o, logic [31:0] aa, logic [31:0] bb);
    logic [31:0] e;
    start = st;
    op    = o;
    a32   = aa;
    b32   = bb;
    for (int k = 0; k < 4; k++) begin
      bit mr;
      mr = (cyc >= busy_until[k]);
      chk($sformatf("ready%0d", k), 32'(rdy[k]), 32'(mr));
      if (st && mr) begin
        e = model(o, aa, bb, wof(k));
        q[k].push_back('{res: e, acc: cyc + 1});
        busy_until[k] = cyc + 2 + nsl(k);
        if (k == 0) begin
          inflight0 = 1'b1;
          exp0      = e[15:0];
          acc0      = cyc + 1;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic wait_ready0();
    while (cyc < busy_until[0]) drive(1'b0, 3'd0, $urandom, $urandom);
  endtask

  task automatic check_reset_state(string tag);
    chk({tag, "_r0"}, 32'(r0), 32'h0);
    chk({tag, "_r1"}, 32'(r1), 32'h0);
    chk({tag, "_r2"}, r2, 32'h0);
    chk({tag, "_r3"}, 32'(r3), 32'h0);
    chk({tag, "_ready"}, 32'(rdy), 32'hF);
    chk({tag, "_done"}, 32'(dn), 32'h0);
    chk({tag, "_Z"}, 32'(zf), 32'h0);
    chk({tag, "_N"}, 32'(nf), 32'h0);
    chk({tag, "_C"}, 32'(cf), 32'h0);
    chk({tag, "_V"}, 32'(vf), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish within 200000 time units");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 4; k++) busy_until[k] = 0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    // Directed cases from the datasheet examples.
    drive(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    wait_ready0();
    drive(1'b1, OP_XOR, 32'h0000_1234, 32'h0000_1234);
    wait_ready0();
    drive(1'b1, OP_NOTA, 32'h0, $urandom);
    wait_ready0();

    // Starts during BUSY/DONE are ignored; the held start is taken once ready returns.
    drive(1'b1, OP_OR, 32'h0000_00A5, 32'h0000_5A00);
    repeat (6) drive(1'b1, OP_XNOR, $urandom, $urandom);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    wait_ready0();

    // NAND of all-ones, then operands wander while idle.
    drive(1'b1, OP_NAND, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_ready0();
    repeat (10) drive(1'b0, 3'($urandom), $urandom, $urandom);

    // Asynchronous reset while unit 0 computes its third slice.
    drive(1'b1, OP_AND, 32'h0000_F0F0, 32'h0000_FF00);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b0, 3'd0, 32'h0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_reset");
    for (int k = 0; k < 4; k++) begin
      q[k].delete();
      busy_until[k] = 0;
    end
    inflight0 = 1'b0;
    last_r0   = '0;
    last_z0   = 1'b0;
    last_n0   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) drive(1'b0, 3'd0, 32'h0, 32'h0);
    drive(1'b1, OP_ANDN, 32'h0000_F0F0, 32'h0000_FF00);
    wait_ready0();

    // Every op once on random operands, then a random start stream.
    for (int o = 0; o < 8; o++) begin
      drive(1'b1, 3'(o), $urandom, $urandom);
      wait_ready0();
    end
    repeat (400) drive(1'($urandom_range(0, 1)), 3'($urandom), $urandom, $urandom);

    repeat (40) drive(1'b0, 3'd0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) chk($sformatf("drained%0d", k), 32'(q[k].size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
